normalize_unit: RTL and testbench
=================================

NORMALIZE_UNIT -- requirements
Module: normalize_unit

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand presented.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 a  input  DATA_WIDTH  operand to normalize.
REQ-007 signed_mode  input  1  0 = unsigned (leading-zero) normalize, 1 = signed (sign-bit) normalize; sampled with a.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 normalized  output  DATA_WIDTH  operand shifted left by shift_count.
REQ-011 shift_count  output  6  number of left shifts applied, range 0..32.
REQ-012 zero  output  1  captured operand was all zeros.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 IDLE: on in_valid&in_ready, capture a into the work register, capture signed_mode, clear count, set zero=(a==0), go to SHIFT.
REQ-015 Limit SHALL be 32 (DATA_WIDTH) in unsigned mode and 31 (DATA_WIDTH-1) in signed mode.
REQ-016 Normalized condition SHALL be work[31]==1 (unsigned) or work[31]!=work[30] (signed).
REQ-017 SHIFT, each cycle: if condition true or count==limit -> DONE with no shift; else work <= work<<1 with zero fill, count <= count+1.
REQ-018 Exactly one bit of shift per SHIFT cycle; no multi-bit steps.
REQ-019 Latency: out_valid SHALL rise shift_count+1 cycles after the accepting edge (min 1, max 33).
REQ-020 Unsigned zero operand SHALL give shift_count=32, normalized=0, zero=1.
REQ-021 Signed all-zeros operand SHALL give shift_count=31, normalized=0, zero=1; signed all-ones SHALL give shift_count=31, normalized=0x8000_0000, zero=0.
REQ-022 DONE: normalized, shift_count, zero SHALL be held stable until out_valid&out_ready; then go to IDLE.
REQ-023 in_valid while not in IDLE SHALL be ignored (no queuing, no overlap); a and signed_mode changes after capture SHALL not affect the result.
REQ-024 in_ready SHALL not depend combinationally on out_ready; next acceptance is at earliest one cycle after the result handshake.
REQ-025 shift_count SHALL never exceed the mode limit; count width 6 bits with no wrap.

Reset
REQ-026 With rst high at a clock edge: state=IDLE, work register=0, shift_count=0, zero=0, out_valid=0, in_ready=1 in the following cycle.
REQ-027 Reset SHALL take priority over every handshake, including assertion mid-SHIFT or in DONE with out_ready low; the in-flight operation SHALL be discarded with no result emitted.

Structure
REQ-028 The state enum norm_state_t (IDLE, SHIFT, DONE) SHALL live in the shared ALU package alu_pkg together with the shift-count width constant.
REQ-029 The block SHALL be a single module with no sub-module; FSM, work register and counter in one clocked process, condition logic combinational.

Verification
REQ-030 Unsigned a=0x0000_0001 -> normalized=0x8000_0000, shift_count=31, zero=0, out_valid 32 cycles after accept.
REQ-031 Unsigned a=0x8000_0000 -> shift_count=0, normalized=0x8000_0000, out_valid 1 cycle after accept; unsigned a=0 -> shift_count=32, normalized=0, zero=1, latency 33.
REQ-032 Signed a=0xFFFF_FFF0 -> shift_count=27, normalized=0x8000_0000; signed a=0x0000_0100 -> shift_count=22, normalized=0x4000_0000.
REQ-033 Signed a=0xFFFF_FFFF -> shift_count=31, normalized=0x8000_0000, zero=0; signed a=0 -> shift_count=31, zero=1.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling a and in_valid -> outputs stable, in_ready=0, no second acceptance; result then consumed exactly once.
REQ-035 Reset asserted 10 cycles into SHIFT on a=0x0000_0001 -> out_valid never asserts, next cycle in_ready=1, shift_count=0; a following a=0x0000_0010 unsigned yields shift_count=27, normalized=0x8000_0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// FSM state encoding and shift-count width for the normalize unit.
package alu_pkg;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } norm_state_t;

endpackage

// File: rtl/normalize_unit.sv
// Iterative normalizer: shifts the operand left one bit per cycle
// until the top bit (unsigned) or the sign boundary (signed) is reached.
module normalize_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic                  signed_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] normalized,
    output logic [CNT_W-1:0]      shift_count,
    output logic                  zero
);

    norm_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  zero_q, zero_d;
    logic                  mode_q, mode_d;

    logic                  norm_ok;
    logic [CNT_W-1:0]      limit;

    // Signed mode stops one short: the sign bit itself is never shifted out.
    assign limit = mode_q ? CNT_W'(DATA_WIDTH - 1) : CNT_W'(DATA_WIDTH);

    assign norm_ok = mode_q
        ? (work_q[DATA_WIDTH-1] != work_q[DATA_WIDTH-2])
        : work_q[DATA_WIDTH-1];

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        zero_d  = zero_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = a;
                    mode_d  = signed_mode;
                    count_d = '0;
                    zero_d  = (a == '0);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (norm_ok || (count_q == limit)) begin
                    state_d = DONE;
                end else begin
                    work_d  = {work_q[DATA_WIDTH-2:0], 1'b0};
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            zero_q  <= zero_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign normalized  = work_q;
    assign shift_count = count_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_normalize_unit.sv
// Bench for normalize_unit: vector table, random operands against a
// leading-bit model, backpressure and mid-operation reset sequences.
module tb_normalize_unit;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic          signed_mode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] normalized;
    logic [5:0]    shift_count;
    logic          zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] n;
        logic [5:0]  c;
        logic        z;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic        sm;
        logic [31:0] en;
        logic [5:0]  ec;
        logic        ez;
        int          hold;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];

    normalize_unit #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .normalized  (normalized),
        .shift_count (shift_count),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: locate the most significant bit that differs from the
    // fill pattern, independent of any shifting loop.
    function automatic exp_t model(input logic [31:0] v, input logic sm);
        exp_t e;
        int   c;
        if (!sm) begin
            c = 32;
            for (int i = 0; i < 32; i++)
                if (v[i]) c = 31 - i;
        end else begin
            c = 31;
            for (int i = 0; i < 31; i++)
                if (v[i] != v[31]) c = 30 - i;
        end
        e.n = v << c;
        e.c = 6'(c);
        e.z = (v == 32'd0);
        return e;
    endfunction

    // Result consumer: one pop per DONE cycle that ends in a handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_result: got %h with no pending operand",
                         normalized);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_normalized", normalized, e.n);
                chk("sb_shift_count", 32'(shift_count), 32'(e.c));
                chk("sb_zero", 32'(zero), 32'(e.z));
            end
        end
    end

    task automatic run_op(input logic [31:0] av, input logic sm,
                          input exp_t e, input int hold);
        logic [31:0] cap_n;
        logic [5:0]  cap_c;
        logic        cap_z;
        int          k;
        bit          got;
        @(negedge clk);
        a           = av;
        signed_mode = sm;
        in_valid    = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        sb.push_back(e);
        #1;
        in_valid    = 1'b0;
        a           = $urandom;
        signed_mode = ~sm;
        got = 1'b0;
        k   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                got = 1'b1;
                k   = i;
                break;
            end
            in_valid = 1'($urandom_range(0, 1));
            a        = $urandom;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no out_valid in 40 cycles for a=%h", av);
            in_valid = 1'b0;
            return;
        end
        chk("latency", 32'(k), 32'(e.c) + 32'd1);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        cap_n = normalized;
        cap_c = shift_count;
        cap_z = zero;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = $urandom;
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_norm", normalized, cap_n);
            chk("hold_cnt", 32'(shift_count), 32'(cap_c));
            chk("hold_zero", 32'(zero), 32'(cap_z));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        tbl[0]  = '{32'h0000_0001, 1'b0, 32'h8000_0000, 6'd31, 1'b0, 0};
        tbl[1]  = '{32'h8000_0000, 1'b0, 32'h8000_0000, 6'd0,  1'b0, 0};
        tbl[2]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1, 1};
        tbl[3]  = '{32'hFFFF_FFF0, 1'b1, 32'h8000_0000, 6'd27, 1'b0, 5};
        tbl[4]  = '{32'h0000_0100, 1'b1, 32'h4000_0000, 6'd22, 1'b0, 0};
        tbl[5]  = '{32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 6'd31, 1'b0, 2};
        tbl[6]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 6'd31, 1'b1, 0};
        tbl[7]  = '{32'h0000_FFFF, 1'b0, 32'hFFFF_0000, 6'd16, 1'b0, 0};
        tbl[8]  = '{32'h4000_0000, 1'b1, 32'h4000_0000, 6'd0,  1'b0, 0};
        tbl[9]  = '{32'hC000_0000, 1'b1, 32'h8000_0000, 6'd1,  1'b0, 3};
        tbl[10] = '{32'h0001_0000, 1'b0, 32'h8000_0000, 6'd15, 1'b0, 0};
        tbl[11] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 6'd0,  1'b0, 0};

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_cnt", 32'(shift_count), 32'd0);
        chk("rst_norm", normalized, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            e.n = tbl[i].en;
            e.c = tbl[i].ec;
            e.z = tbl[i].ez;
            run_op(tbl[i].a, tbl[i].sm, e, tbl[i].hold);
        end

        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            logic        sm;
            v  = $urandom >> $urandom_range(0, 31);
            sm = 1'($urandom_range(0, 1));
            if (sm && $urandom_range(0, 1) == 1) v = ~v;
            run_op(v, sm, model(v, sm), $urandom_range(0, 2));
        end

        // Reset mid-SHIFT: operand is discarded without a result.
        @(negedge clk);
        a           = 32'h0000_0001;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("shift_no_valid", 32'(out_valid), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_cnt", 32'(shift_count), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_zero", 32'(zero), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midrst_quiet", 32'(out_valid), 32'd0);
        end
        e.n = 32'h8000_0000;
        e.c = 6'd27;
        e.z = 1'b0;
        run_op(32'h0000_0010, 1'b0, e, 0);

        // Reset in DONE with out_ready low.
        @(negedge clk);
        a           = 32'h8000_0000;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("done_reached", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("donerst_valid", 32'(out_valid), 32'd0);
        chk("donerst_ready", 32'(in_ready), 32'd1);
        chk("donerst_norm", normalized, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
